// File: rtl/qdma_sched.sv
// qdma_sched: round-robin DMA scheduler in front of the QBUS bus-master engine.
// Grants one word per bus tenure, with a per-channel burst quota before rotating.
module qdma_sched #(
  parameter int NREQ  = 4,
  parameter int AW    = 22,
  parameter int CW    = 16,
  parameter int BURST = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               qinit_i,
  input  logic [NREQ-1:0]    ch_start_i,
  input  logic [NREQ-1:0]    ch_write_i,
  input  logic [NREQ*AW-1:0] ch_addr_i,
  input  logic [NREQ*CW-1:0] ch_count_i,
  output logic [NREQ-1:0]    ch_busy_o,
  output logic [NREQ-1:0]    ch_word_o,
  output logic [NREQ-1:0]    ch_done_o,
  output logic [NREQ-1:0]    ch_err_o,
  output logic               dma_read_o,
  output logic               dma_write_o,
  output logic [AW-1:0]      dma_addr_o,
  output logic [NREQ-1:0]    dma_sel_o,
  input  logic               bus_master_i,
  input  logic               dma_complete_i,
  input  logic               nxm_i
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, REQ, RETIRE} state_t;

  state_t          state_q;
  logic [NREQ-1:0] busy_q;
  logic [NREQ-1:0] write_q;
  logic [AW-1:0]   addr_q   [NREQ];
  logic [CW-1:0]   remain_q [NREQ];
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   cur_q;
  logic [BW-1:0]   burst_q;
  logic [NREQ-1:0] ch_word_q;
  logic [NREQ-1:0] ch_done_q;
  logic [NREQ-1:0] ch_err_q;
  logic            dma_read_q;
  logic            dma_write_q;
  logic [AW-1:0]   dma_addr_q;
  logic [NREQ-1:0] dma_sel_q;

  logic            found_d;
  logic [IW-1:0]   pick_d;
  logic [IW:0]     scan_d;
  logic [IW-1:0]   rr_next_d;

  // First busy channel at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    scan_d  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_d = {1'b0, rr_q} + (IW+1)'(k);
      if (scan_d >= (IW+1)'(NREQ)) scan_d = scan_d - (IW+1)'(NREQ);
      if (!found_d && busy_q[scan_d[IW-1:0]]) begin
        found_d = 1'b1;
        pick_d  = scan_d[IW-1:0];
      end
    end
    rr_next_d = (cur_q == IW'(NREQ-1)) ? '0 : cur_q + IW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      busy_q      <= '0;
      write_q     <= '0;
      rr_q        <= '0;
      cur_q       <= '0;
      burst_q     <= '0;
      ch_word_q   <= '0;
      ch_done_q   <= '0;
      ch_err_q    <= '0;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_sel_q   <= '0;
      for (int c = 0; c < NREQ; c++) begin
        addr_q[c]   <= '0;
        remain_q[c] <= '0;
      end
    end else if (qinit_i) begin
      state_q     <= IDLE;
      busy_q      <= '0;
      rr_q        <= '0;
      cur_q       <= '0;
      burst_q     <= '0;
      ch_word_q   <= '0;
      ch_done_q   <= '0;
      ch_err_q    <= '0;
      dma_read_q  <= 1'b0;
      dma_write_q <= 1'b0;
      dma_addr_q  <= '0;
      dma_sel_q   <= '0;
    end else begin
      ch_word_q <= '0;
      ch_done_q <= '0;
      ch_err_q  <= '0;

      for (int c = 0; c < NREQ; c++) begin
        if (ch_start_i[c] && !busy_q[c]) begin
          if (ch_count_i[c*CW +: CW] == '0) begin
            ch_done_q[c] <= 1'b1;
          end else begin
            busy_q[c]   <= 1'b1;
            write_q[c]  <= ch_write_i[c];
            addr_q[c]   <= {ch_addr_i[c*AW+1 +: AW-1], 1'b0};
            remain_q[c] <= ch_count_i[c*CW +: CW];
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (!bus_master_i && found_d) begin
            if (pick_d != cur_q) burst_q <= '0;
            cur_q       <= pick_d;
            dma_sel_q   <= NREQ'(1) << pick_d;
            dma_addr_q  <= addr_q[pick_d];
            dma_read_q  <= !write_q[pick_d];
            dma_write_q <= write_q[pick_d];
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (dma_complete_i || nxm_i) begin
            dma_read_q  <= 1'b0;
            dma_write_q <= 1'b0;
            state_q     <= RETIRE;
            // nxm wins when both arrive together
            if (nxm_i) begin
              ch_err_q[cur_q] <= 1'b1;
              busy_q[cur_q]   <= 1'b0;
            end else begin
              ch_word_q[cur_q] <= 1'b1;
              addr_q[cur_q]    <= addr_q[cur_q] + AW'(2);
              remain_q[cur_q]  <= remain_q[cur_q] - CW'(1);
              burst_q          <= burst_q + BW'(1);
              if (remain_q[cur_q] == CW'(1)) begin
                ch_done_q[cur_q] <= 1'b1;
                busy_q[cur_q]    <= 1'b0;
              end
            end
          end
        end
        RETIRE: begin
          if (!bus_master_i) begin
            state_q    <= IDLE;
            dma_sel_q  <= '0;
            dma_addr_q <= '0;
            if (!(busy_q[cur_q] && burst_q < BW'(BURST))) begin
              rr_q    <= rr_next_d;
              burst_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_busy_o   = busy_q;
  assign ch_word_o   = ch_word_q;
  assign ch_done_o   = ch_done_q;
  assign ch_err_o    = ch_err_q;
  assign dma_read_o  = dma_read_q;
  assign dma_write_o = dma_write_q;
  assign dma_addr_o  = dma_addr_q;
  assign dma_sel_o   = dma_sel_q;

endmodule

// File: doc/qdma_sched.md
Name: qdma_sched

Overview:
- Multi-channel DMA scheduler in front of the QBUS master sequencer.
- Each of NREQ device channels (disk, tape and similar controllers) loads a block descriptor: start address, word count, direction.
- The block grants the single bus-master engine one word per bus tenure, round-robin, with a per-channel burst quota.
- It supplies the word address and channel select to the DAL datapath mux and retires words on dma_complete or nxm.

Parameters:
NREQ, 4, number of requester channels (2..8)
AW, 22, QBUS address width
CW, 16, word-count width
BURST, 4, consecutive words granted to one channel before the round-robin pointer advances (1..16)

Ports:
clk  in  1  20MHz system clock
reset_n  in  1  asynchronous, active-low reset
qinit  in  1  RINIT from bus receivers, active-high, sampled synchronously
ch_start  in  NREQ  one-clock pulse per channel: latch that channel's descriptor
ch_write  in  NREQ  per-channel direction at start, 1 = write to QBUS memory
ch_addr  in  NREQ*AW  per-channel start byte address; bit 0 ignored
ch_count  in  NREQ*CW  per-channel word count
ch_busy  out  NREQ  channel holds an unfinished descriptor
ch_word  out  NREQ  one-clock pulse: one word of that channel retired successfully
ch_done  out  NREQ  one-clock pulse: descriptor finished, no error
ch_err  out  NREQ  one-clock pulse: descriptor aborted by NXM
dma_read  out  1  request a read cycle from the master
dma_write  out  1  request a write cycle from the master
dma_addr  out  AW  address of the current word; bit 0 always 0
dma_sel  out  NREQ  one-hot current channel, for the data mux
bus_master  in  1  master owns the bus
dma_complete  in  1  master: word transferred (1-clock pulse)
nxm  in  1  master: NXM timeout (1-clock pulse)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, all channels idle, rr pointer = 0, state IDLE.
- qinit high (synchronous, each clock): same clearing as reset. No done/err pulses; ch_start ignored.
- Channel regs: busy, write, addr (AW), remaining (CW).
- ch_start on an idle channel with count != 0: latch descriptor; busy=1 next clock.
- ch_start with count = 0: ch_done pulse next clock; busy stays 0.
- ch_start on a busy channel: ignored.
- States:
  - IDLE: wait while bus_master=1. Otherwise select the first busy channel scanning from rr pointer upward (mod NREQ). On the next edge drive dma_sel, dma_addr and dma_read/dma_write (from channel write bit); go to REQ. No busy channel: stay IDLE, outputs 0.
  - REQ: hold the request. On dma_complete or nxm (first seen), the next edge drops dma_read/dma_write and goes to RETIRE.
    - nxm: ch_err pulse; channel busy=0.
    - otherwise: ch_word pulse; addr += 2 (mod 2^AW); remaining -= 1; burst counter += 1.
    - remaining reaching 0 pulses ch_done, busy=0.
    - dma_complete and nxm in the same clock: treated as nxm.
  - RETIRE: dma_sel and dma_addr held. Ignore further dma_complete/nxm (a read NXM yields a later dma_complete). Leave when bus_master=0 (and at least one clock in RETIRE).
    - If channel still busy and burst counter < BURST: go to IDLE with the same channel preferred (rr pointer unchanged).
    - Otherwise: rr pointer = channel+1 mod NREQ; burst counter = 0.
- Burst counter also clears whenever the selected channel differs from the previous one.
- dma_read and dma_write are never both 1. Both are registered, glitch-free, and never asserted while in RETIRE.
- Timing:
  - dma_* rises 2 clocks after ch_start in an idle system.
  - dma_* falls exactly 1 clock after the retire pulse input.
- No timeout: the master guarantees nxm.
- Address wrap: 0x3FFFFE + 2 → 0x000000, no error.

Test Plan:
- Single read: ch0 start addr 0x001000, count 3, write 0. Drive dma_complete per word.
  → dma_addr 0x001000, 0x001002, 0x001004.
  → 3 ch_word pulses, ch_done after the 3rd; dma_read high 2 clocks after start.
- Round robin, BURST=4: ch1 and ch2 both count 10.
  → grant sequence 1×4, 2×4, 1×4, 2×4, 1×2, 2×2.
  → done pulses for ch1 then ch2.
- NXM on read: ch3 count 5, nxm on word 2, then a dma_complete 3 clocks later.
  → ch_err once, no ch_done, late dma_complete ignored; ch3 busy=0; 1 ch_word total.
- Simultaneous dma_complete and nxm on a write → ch_err, no ch_word.
- Edge cases:
  - count 0 → ch_done next clock, no dma request.
  - start addr 0x3FFFFE, count 2 → addresses 0x3FFFFE, 0x000000.
- qinit mid-transfer (in REQ), then reset_n low mid-REQ.
  → dma_read 0 next clock (qinit) or immediately (reset_n).
  → all busy 0, no done/err, rr pointer 0.
  → restart works normally.
